// File: rtl/glitch_trigger_wb_pkg.sv
// Shared constants for the glitch trigger: register addresses, match modes, FSM states.
// Also provides the edge/level match helper used by the trigger core.
package glitch_trigger_wb_pkg;

   localparam logic [3:0] GLITCH_TRIG_CTRL      = 4'd0;
   localparam logic [3:0] GLITCH_TRIG_MODE      = 4'd1;
   localparam logic [3:0] GLITCH_TRIG_COUNT_0   = 4'd2;
   localparam logic [3:0] GLITCH_TRIG_COUNT_1   = 4'd3;
   localparam logic [3:0] GLITCH_TRIG_STATUS    = 4'd4;
   localparam logic [3:0] GLITCH_TRIG_EVENTS    = 4'd5;
   localparam logic [3:0] GLITCH_TRIG_TIMEOUT_0 = 4'd6;
   localparam logic [3:0] GLITCH_TRIG_TIMEOUT_1 = 4'd7;

   localparam logic [1:0] GLITCH_TRIG_RISE  = 2'd0;
   localparam logic [1:0] GLITCH_TRIG_FALL  = 2'd1;
   localparam logic [1:0] GLITCH_TRIG_BOTH  = 2'd2;
   localparam logic [1:0] GLITCH_TRIG_LEVEL = 2'd3;

   typedef enum logic [1:0] {
      TRIG_IDLE  = 2'd0,
      TRIG_ARMED = 2'd1,
      TRIG_FIRE  = 2'd2
   } trig_state_e;

   // cur is the synchronised sample, prev the one before it
   function automatic logic trig_match(input logic [1:0] mode, input logic cur, input logic prev);
      logic m;
      case (mode)
         GLITCH_TRIG_RISE: m = cur & ~prev;
         GLITCH_TRIG_FALL: m = ~cur & prev;
         GLITCH_TRIG_BOTH: m = cur ^ prev;
         default:          m = cur;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/glitch_trigger_wb_if.sv
// Wishbone slave bus bundle for the glitch trigger register file.
interface glitch_trigger_wb_if;
   logic [7:0] dat_i;
   logic [3:0] adr_i;
   logic [7:0] dat_o;
   logic       stb_i;
   logic       we_i;
   logic       ack_o;

   modport slave  (input dat_i, adr_i, stb_i, we_i, output dat_o, ack_o);
   modport master (output dat_i, adr_i, stb_i, we_i, input dat_o, ack_o);
endinterface

// File: rtl/glitch_trigger_wb_core.sv
// Trigger core: input synchroniser, edge/level detect, event counter and arm/fire FSM.
// GLITCH_TRIGGER_TIMEOUT_EN adds the armed-state timeout counter.
module glitch_trigger_core
   import glitch_trigger_wb_pkg::*;
#(
   parameter int CNT_W = 16
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
   , parameter int TMO_W = 16
`endif
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             trig_in,
   input  logic             glitch_rdy_i,
   input  logic             arm_i,
   input  logic             abort_i,
   input  logic             auto_i,
   input  logic [1:0]       mode_i,
   input  logic [CNT_W-1:0] target_i,
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
   input  logic [TMO_W-1:0] timeout_i,
   output logic             tmo_set_o,
`endif
   output logic             armed_o,
   output logic             fired_set_o,
   output logic             missed_set_o,
   output logic [7:0]       events_lo_o,
   output logic             trig_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             sync1_q, sync2_q, hist_q;
   trig_state_e      state_q, state_d;
   logic [CNT_W-1:0] events_q, events_d;
   logic             trig_q, trig_d;
   logic             match, reached;
   logic [CNT_W-1:0] eff_target, events_inc;

`ifdef GLITCH_TRIGGER_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_hit;
   assign tmo_hit = (timeout_i != '0) && (tmo_q >= timeout_i - TMO_ONE);
`endif

   assign match      = trig_match(mode_i, sync2_q, hist_q);
   assign eff_target = (target_i == '0) ? CNT_ONE : target_i;
   assign reached    = events_q >= (eff_target - CNT_ONE);
   assign events_inc = (&events_q) ? events_q : events_q + CNT_ONE;

   always_comb begin
      state_d      = state_q;
      events_d     = events_q;
      trig_d       = 1'b0;
      fired_set_o  = 1'b0;
      missed_set_o = 1'b0;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
      tmo_d        = tmo_q;
      tmo_set_o    = 1'b0;
`endif
      case (state_q)
         TRIG_IDLE: begin
            if (arm_i && !abort_i) begin
               state_d  = TRIG_ARMED;
               events_d = '0;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
               tmo_d    = '0;
`endif
            end
         end
         TRIG_ARMED: begin
            // Priority: abort, re-arm, match, then timeout
            if (abort_i) begin
               state_d = TRIG_IDLE;
            end else if (arm_i) begin
               events_d = '0;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
               tmo_d    = '0;
`endif
            end else if (match) begin
               events_d = events_inc;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
               tmo_d    = '0;
`endif
               if (reached) state_d = TRIG_FIRE;
            end
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d   = TRIG_IDLE;
               tmo_set_o = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_ONE;
            end
`endif
         end
         TRIG_FIRE: begin
            trig_d       = glitch_rdy_i;
            fired_set_o  = glitch_rdy_i;
            missed_set_o = ~glitch_rdy_i;
            if (!abort_i && (arm_i || auto_i)) begin
               state_d  = TRIG_ARMED;
               events_d = '0;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
               tmo_d    = '0;
`endif
            end else begin
               state_d = TRIG_IDLE;
            end
         end
         default: state_d = TRIG_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         hist_q   <= 1'b0;
         state_q  <= TRIG_IDLE;
         events_q <= '0;
         trig_q   <= 1'b0;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else begin
         sync1_q  <= trig_in;
         sync2_q  <= sync1_q;
         hist_q   <= sync2_q;
         state_q  <= state_d;
         events_q <= events_d;
         trig_q   <= trig_d;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   assign armed_o     = (state_q != TRIG_IDLE);
   assign events_lo_o = events_q[7:0];
   assign trig_o      = trig_q;

endmodule

// File: rtl/glitch_trigger_wb.sv
// Wishbone register file for the glitch trigger; detection and FSM live in glitch_trigger_core.
// Optional macro GLITCH_TRIGGER_TIMEOUT_EN maps TIMEOUT_0/1 and STATUS bit3.
module glitch_trigger_wb
   import glitch_trigger_wb_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int TMO_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   glitch_trigger_wb_if.slave   wb,
   input  logic                 trig_in,
   input  logic                 glitch_rdy_i,
   output logic                 trig_o
);

   logic       ack_q, ack_d;
   logic [7:0] dat_q, dat_d;
   logic       auto_q, auto_d;
   logic [1:0] mode_q, mode_d;
   logic [7:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic       fired_q, fired_d, missed_q, missed_d;
   logic       access, wr, rd, ctrl_wr, status_rd;
   logic       arm, abort, armed, fired_set, missed_set;
   logic [7:0] events_lo, rdata;
   logic       tmo_flag;

   assign access    = wb.stb_i & ~ack_q;
   assign wr        = access & wb.we_i;
   assign rd        = access & ~wb.we_i;
   assign ctrl_wr   = wr && (wb.adr_i == GLITCH_TRIG_CTRL);
   assign status_rd = rd && (wb.adr_i == GLITCH_TRIG_STATUS);
   assign arm       = ctrl_wr & wb.dat_i[0];
   assign abort     = ctrl_wr & wb.dat_i[2];

`ifdef GLITCH_TRIGGER_TIMEOUT_EN
   logic [7:0] tmo0_q, tmo0_d, tmo1_q, tmo1_d;
   logic       tmo_flag_q, tmo_flag_d, tmo_set;
   assign tmo_flag = tmo_flag_q;
`else
   assign tmo_flag = 1'b0;
`endif

   always_comb begin
      rdata = 8'h00;
      case (wb.adr_i)
         GLITCH_TRIG_CTRL:      rdata = {6'b0, auto_q, armed};
         GLITCH_TRIG_MODE:      rdata = {6'b0, mode_q};
         GLITCH_TRIG_COUNT_0:   rdata = cnt0_q;
         GLITCH_TRIG_COUNT_1:   rdata = cnt1_q;
         GLITCH_TRIG_STATUS:    rdata = {4'b0, tmo_flag, missed_q, fired_q, armed};
         GLITCH_TRIG_EVENTS:    rdata = events_lo;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
         GLITCH_TRIG_TIMEOUT_0: rdata = tmo0_q;
         GLITCH_TRIG_TIMEOUT_1: rdata = tmo1_q;
`endif
         default:               rdata = 8'h00;
      endcase
   end

   always_comb begin
      ack_d  = access;
      dat_d  = rd ? rdata : 8'h00;
      auto_d = auto_q;
      mode_d = mode_q;
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
      tmo0_d = tmo0_q;
      tmo1_d = tmo1_q;
`endif
      if (wr) begin
         case (wb.adr_i)
            GLITCH_TRIG_CTRL:      auto_d = wb.dat_i[1];
            GLITCH_TRIG_MODE:      mode_d = wb.dat_i[1:0];
            GLITCH_TRIG_COUNT_0:   cnt0_d = wb.dat_i;
            GLITCH_TRIG_COUNT_1:   cnt1_d = wb.dat_i;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
            GLITCH_TRIG_TIMEOUT_0: tmo0_d = wb.dat_i;
            GLITCH_TRIG_TIMEOUT_1: tmo1_d = wb.dat_i;
`endif
            default: ;
         endcase
      end
      // A set on the same edge as the clearing STATUS read wins
      fired_d  = (fired_q  & ~status_rd) | fired_set;
      missed_d = (missed_q & ~status_rd) | missed_set;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
      tmo_flag_d = (tmo_flag_q & ~status_rd) | tmo_set;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_q    <= 1'b0;
         dat_q    <= 8'h00;
         auto_q   <= 1'b0;
         mode_q   <= 2'b00;
         cnt0_q   <= 8'h00;
         cnt1_q   <= 8'h00;
         fired_q  <= 1'b0;
         missed_q <= 1'b0;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
         tmo0_q     <= 8'h00;
         tmo1_q     <= 8'h00;
         tmo_flag_q <= 1'b0;
`endif
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         auto_q   <= auto_d;
         mode_q   <= mode_d;
         cnt0_q   <= cnt0_d;
         cnt1_q   <= cnt1_d;
         fired_q  <= fired_d;
         missed_q <= missed_d;
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
         tmo0_q     <= tmo0_d;
         tmo1_q     <= tmo1_d;
         tmo_flag_q <= tmo_flag_d;
`endif
      end
   end

   assign wb.ack_o = ack_q;
   assign wb.dat_o = dat_q;

   glitch_trigger_core #(
      .CNT_W(CNT_W)
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
      , .TMO_W(TMO_W)
`endif
   ) u_core (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .trig_in      (trig_in),
      .glitch_rdy_i (glitch_rdy_i),
      .arm_i        (arm),
      .abort_i      (abort),
      .auto_i       (auto_q),
      .mode_i       (mode_q),
      .target_i     (CNT_W'({cnt1_q, cnt0_q})),
`ifdef GLITCH_TRIGGER_TIMEOUT_EN
      .timeout_i    (TMO_W'({tmo1_q, tmo0_q})),
      .tmo_set_o    (tmo_set),
`endif
      .armed_o      (armed),
      .fired_set_o  (fired_set),
      .missed_set_o (missed_set),
      .events_lo_o  (events_lo),
      .trig_o       (trig_o)
   );

endmodule

// File: tb/tb_glitch_trigger_wb.sv
// Directed testbench for glitch_trigger_wb with queue-based scoreboard for reads and trigger pulses.
module tb_glitch_trigger_wb;
   import glitch_trigger_wb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic trig_in = 1'b0;
   logic rdy = 1'b1;
   logic trig_o;

   glitch_trigger_wb_if wb_if ();

   glitch_trigger_wb #(.CNT_W(16), .TMO_W(16)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .wb           (wb_if),
      .trig_in      (trig_in),
      .glitch_rdy_i (rdy),
      .trig_o       (trig_o)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_pulse_q[$];
   logic [7:0] exp_rd_q[$];
   logic prev_trig = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse scoreboard: each trig_o cycle must match the next expected cycle
   always @(negedge clk) begin
      if (trig_o === 1'b1) begin
         chk("trig_consecutive", {31'b0, prev_trig}, 32'd0);
         if (exp_pulse_q.size() > 0) chk("trig_cycle", cyc, exp_pulse_q.pop_front());
         else chk("trig_unexpected", {31'b0, trig_o}, 32'd0);
      end
      prev_trig = (trig_o === 1'b1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [3:0] adr, input logic [7:0] d);
      wb_if.adr_i = adr;
      wb_if.dat_i = d;
      wb_if.we_i  = 1'b1;
      wb_if.stb_i = 1'b1;
      step();
      wb_if.stb_i = 1'b0;
      wb_if.we_i  = 1'b0;
      chk("wr_ack", {31'b0, wb_if.ack_o}, 32'd1);
      step();
      chk("wr_ack_drop", {31'b0, wb_if.ack_o}, 32'd0);
   endtask

   task automatic wb_read(input logic [3:0] adr, input logic [7:0] exp, input string tag);
      logic got;
      exp_rd_q.push_back(exp);
      wb_if.adr_i = adr;
      wb_if.we_i  = 1'b0;
      wb_if.stb_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         step();
         wb_if.stb_i = 1'b0;
         if (wb_if.ack_o === 1'b1) got = 1'b1;
      end
      chk({tag, "_ack"}, {31'b0, got}, 32'd1);
      chk(tag, {24'b0, wb_if.dat_o}, {24'b0, exp_rd_q.pop_front()});
      step();
      chk({tag, "_ack_drop"}, {31'b0, wb_if.ack_o}, 32'd0);
   endtask

   // One high pulse on trig_in; optionally expect a trigger `lat` cycles after the first high sample
   task automatic pulse(input bit expect_fire, input int lat, input int hi, input int lo);
      trig_in = 1'b1;
      if (expect_fire) exp_pulse_q.push_back(cyc + 1 + lat);
      repeat (hi) step();
      trig_in = 1'b0;
      repeat (lo) step();
   endtask

   task automatic toggle(input bit expect_fire);
      trig_in = ~trig_in;
      if (expect_fire) exp_pulse_q.push_back(cyc + 1 + 3);
      repeat (2) step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wb_if.stb_i = 1'b0;
      wb_if.we_i  = 1'b0;
      wb_if.adr_i = 4'd0;
      wb_if.dat_i = 8'd0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_ack", {31'b0, wb_if.ack_o}, 32'd0);
      chk("rst_dat", {24'b0, wb_if.dat_o}, 32'd0);
      chk("rst_trig", {31'b0, trig_o}, 32'd0);
      wb_read(GLITCH_TRIG_STATUS, 8'h00, "rst_status");
      wb_read(GLITCH_TRIG_CTRL,   8'h00, "rst_ctrl");
      wb_read(GLITCH_TRIG_EVENTS, 8'h00, "rst_events");

      // Rising mode, target 3
      wb_write(GLITCH_TRIG_MODE, 8'h00);
      wb_write(GLITCH_TRIG_COUNT_0, 8'h03);
      wb_write(GLITCH_TRIG_COUNT_1, 8'h00);
      wb_read(GLITCH_TRIG_COUNT_0, 8'h03, "count0_rb");
      wb_write(GLITCH_TRIG_CTRL, 8'h01);
      wb_read(GLITCH_TRIG_STATUS, 8'h01, "armed_status");
      pulse(1'b0, 3, 2, 3);
      pulse(1'b0, 3, 2, 3);
      pulse(1'b1, 3, 2, 6);
      chk("rise_pulse_seen", exp_pulse_q.size(), 32'd0);
      wb_read(GLITCH_TRIG_STATUS, 8'h02, "rise_status");
      wb_read(GLITCH_TRIG_STATUS, 8'h00, "rise_status_clr");

      // Both edges, target 0x0102
      wb_write(GLITCH_TRIG_MODE, 8'h02);
      wb_write(GLITCH_TRIG_COUNT_0, 8'h02);
      wb_write(GLITCH_TRIG_COUNT_1, 8'h01);
      wb_write(GLITCH_TRIG_CTRL, 8'h01);
      for (int i = 0; i < 257; i++) toggle(1'b0);
      repeat (5) step();
      chk("both_no_pulse", exp_pulse_q.size(), 32'd0);
      wb_read(GLITCH_TRIG_EVENTS, 8'h01, "both_events");
      toggle(1'b1);
      repeat (5) step();
      chk("both_pulse_seen", exp_pulse_q.size(), 32'd0);
      wb_read(GLITCH_TRIG_STATUS, 8'h02, "both_status");

      // Glitcher not ready at FIRE
      wb_write(GLITCH_TRIG_MODE, 8'h00);
      wb_write(GLITCH_TRIG_COUNT_0, 8'h01);
      wb_write(GLITCH_TRIG_COUNT_1, 8'h00);
      rdy = 1'b0;
      wb_write(GLITCH_TRIG_CTRL, 8'h01);
      pulse(1'b0, 3, 2, 6);
      wb_read(GLITCH_TRIG_STATUS, 8'h04, "missed_status");
      wb_read(GLITCH_TRIG_CTRL, 8'h00, "missed_idle");
      rdy = 1'b1;

      // Level-high, target 4: four high cycles fire after the fourth synchronised high
      wb_write(GLITCH_TRIG_MODE, 8'h03);
      wb_write(GLITCH_TRIG_COUNT_0, 8'h04);
      wb_write(GLITCH_TRIG_CTRL, 8'h01);
      pulse(1'b1, 6, 4, 8);
      chk("level_pulse_seen", exp_pulse_q.size(), 32'd0);
      wb_read(GLITCH_TRIG_STATUS, 8'h02, "level_status");

      // Auto re-arm, target 1
      wb_write(GLITCH_TRIG_MODE, 8'h00);
      wb_write(GLITCH_TRIG_COUNT_0, 8'h01);
      wb_write(GLITCH_TRIG_CTRL, 8'h03);
      for (int i = 0; i < 4; i++) pulse(1'b1, 3, 2, 8);
      chk("auto_pulses_seen", exp_pulse_q.size(), 32'd0);
      wb_read(GLITCH_TRIG_CTRL, 8'h03, "auto_ctrl");
      wb_write(GLITCH_TRIG_CTRL, 8'h06);
      wb_read(GLITCH_TRIG_CTRL, 8'h02, "abort_ctrl");
      pulse(1'b0, 3, 2, 8);
      wb_read(GLITCH_TRIG_STATUS, 8'h02, "abort_status");

      // Unmapped address: write acked and ignored, read 0
      wb_write(4'd9, 8'hFF);
      wb_read(4'd9, 8'h00, "unmapped_rd");

`ifdef GLITCH_TRIGGER_TIMEOUT_EN
      wb_write(GLITCH_TRIG_CTRL, 8'h00);
      wb_write(GLITCH_TRIG_TIMEOUT_0, 8'd20);
      wb_write(GLITCH_TRIG_TIMEOUT_1, 8'd0);
      wb_read(GLITCH_TRIG_TIMEOUT_0, 8'd20, "tmo_rb");
      wb_write(GLITCH_TRIG_CTRL, 8'h01);
      repeat (5) step();
      wb_read(GLITCH_TRIG_STATUS, 8'h01, "tmo_still_armed");
      repeat (20) step();
      wb_read(GLITCH_TRIG_STATUS, 8'h08, "tmo_status");
      wb_read(GLITCH_TRIG_CTRL, 8'h00, "tmo_idle");
`else
      wb_write(GLITCH_TRIG_TIMEOUT_0, 8'h14);
      wb_read(GLITCH_TRIG_TIMEOUT_0, 8'h00, "tmo0_absent");
      wb_read(GLITCH_TRIG_TIMEOUT_1, 8'h00, "tmo1_absent");
`endif

      repeat (4) step();
      chk("no_pending_pulses", exp_pulse_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
